// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle for the UART receiver.
// Carries the line, the oversample tick, and the delivered byte with its status.
// master = line/tick source and byte consumer; slave = the receiver itself.
interface uart_rx_if;
  logic       rx;
  logic       RX_sample_tick;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx, RX_sample_tick,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  rx, RX_sample_tick,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, even parity, one stop bit, oversampled.
// Latency: byte strobed on the clk edge that handles the mid-stop-bit sample tick.
// No backpressure: each frame is strobed once and must be taken in that cycle.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bad_q, par_bad_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;

  // State register; the synchronizer flops idle high like the line itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic: everything except the synchronizer advances only on a sample tick.
  always_comb begin
    rx_meta_d    = bus.rx;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;

    if (bus.RX_sample_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d    = START;
            tick_cnt_d = '0;
            busy_d     = 1'b1;
          end
        end
        START: begin
          tick_cnt_d = tick_cnt_q + TW'(1);
          if (tick_cnt_q == HALF_M1) begin
            if (!rx_s_q) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
            end else begin
              // Line went back high before mid-bit: a glitch, not a start bit.
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        DATA, PARITY, STOP: begin
          tick_cnt_d = tick_cnt_q + TW'(1);
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            if (state_q == DATA) begin
              shift_d   = {rx_s_q, shift_q[7:1]};
              bit_idx_d = bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) state_d = PARITY;
            end else if (state_q == PARITY) begin
              par_bad_d = rx_s_q ^ (^shift_q);
              state_d   = STOP;
            end else begin
              // Return to IDLE at mid-stop so a back-to-back start edge is caught.
              data_out_d   = shift_q;
              parity_err_d = par_bad_q;
              frame_err_d  = ~rx_s_q;
              data_valid_d = 1'b1;
              busy_d       = 1'b0;
              state_d      = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean, parity, framing, glitch, back-to-back and mid-frame reset.
// The bench drives the serial line bit by bit against its own sample-tick generator.
// Strobed bytes are captured by a monitor and compared against hand-computed values.
module tb_uart_rx;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vld_cnt = 0;
  int   c0;
  int   div = 0;
  logic [9:0] dq[$];

  uart_rx_if bus();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Sample tick every 4 clk, changed on the falling edge.
  always @(negedge clk) begin
    div = (div == 3) ? 0 : div + 1;
    bus.RX_sample_tick = (div == 0);
  end

  // Capture every strobed frame as {parity_err, frame_err, data}.
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      vld_cnt++;
      dq.push_back({bus.parity_err, bus.frame_err, bus.data_out});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (bus.RX_sample_tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'd0, bus.data_out}, 32'h00);
    check("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("rst_perr", {31'd0, bus.parity_err}, 32'd0);
    check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset_n = 1'b1;
    wait_ticks(4);

    // Clean frame 0xA5, parity 0.
    c0 = vld_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    check("clean_cnt", vld_cnt, c0 + 1);
    check("clean_data", {24'd0, bus.data_out}, 32'hA5);
    check("clean_perr", {31'd0, bus.parity_err}, 32'd0);
    check("clean_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("clean_busy", {31'd0, bus.busy}, 32'd0);
    check("clean_vld_low", {31'd0, bus.data_valid}, 32'd0);

    // Parity error: 0x3C has even ones, so parity bit 1 is wrong.
    c0 = vld_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    check("par_cnt", vld_cnt, c0 + 1);
    check("par_data", {24'd0, bus.data_out}, 32'h3C);
    check("par_perr", {31'd0, bus.parity_err}, 32'd1);
    check("par_ferr", {31'd0, bus.frame_err}, 32'd0);

    // Framing error: 0x81 with stop bit 0.
    c0 = vld_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    check("frm_cnt", vld_cnt, c0 + 1);
    check("frm_data", {24'd0, bus.data_out}, 32'h81);
    check("frm_ferr", {31'd0, bus.frame_err}, 32'd1);
    check("frm_perr", {31'd0, bus.parity_err}, 32'd0);
    bus.rx = 1'b1;
    wait_ticks(2 * OS);
    check("frm_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("frm_idle_cnt", vld_cnt, c0 + 1);
    c0 = vld_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    check("after_frm_cnt", vld_cnt, c0 + 1);
    check("after_frm_data", {24'd0, bus.data_out}, 32'h55);
    check("after_frm_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("after_frm_perr", {31'd0, bus.parity_err}, 32'd0);

    // Glitch: 3 ticks low.
    wait_ticks(OS);
    c0 = vld_cnt;
    bus.rx = 1'b0;
    wait_ticks(3);
    bus.rx = 1'b1;
    wait_ticks(2);
    check("glitch_busy_hi", {31'd0, bus.busy}, 32'd1);
    wait_ticks(2 * OS);
    check("glitch_busy_lo", {31'd0, bus.busy}, 32'd0);
    check("glitch_cnt", vld_cnt, c0);
    check("glitch_data", {24'd0, bus.data_out}, 32'h55);

    // Back-to-back frames, no idle in between.
    dq.delete();
    c0 = vld_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    bus.rx = 1'b1;
    wait_ticks(OS);
    check("b2b_cnt", vld_cnt, c0 + 3);
    check("b2b_qsize", dq.size(), 3);
    if (dq.size() == 3) begin
      check("b2b_f0", {22'd0, dq[0]}, {22'd0, 2'b00, 8'h00});
      check("b2b_f1", {22'd0, dq[1]}, {22'd0, 2'b00, 8'hFF});
      check("b2b_f2", {22'd0, dq[2]}, {22'd0, 2'b00, 8'h01});
    end

    // Reset during data bit 4 of 0xC3 (bit 4 is 0).
    wait_ticks(2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    bus.rx = 1'b0;
    wait_ticks(8);
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", {24'd0, bus.data_out}, 32'h00);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("mid_rst_perr", {31'd0, bus.parity_err}, 32'd0);
    check("mid_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    #20;
    bus.rx  = 1'b1;
    reset_n = 1'b1;
    wait_ticks(2 * OS);
    c0 = vld_cnt;
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_ticks(4);
    check("post_rst_cnt", vld_cnt, c0 + 1);
    check("post_rst_data", {24'd0, bus.data_out}, 32'h5A);
    check("post_rst_perr", {31'd0, bus.parity_err}, 32'd0);
    check("post_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
